// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N:1 stream mux, registered output, manual or round-robin grant.
// Optional beat counter port enabled by defining STREAM_MUX_BEAT_CNT_EN.
module stream_mux_rr #(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_CH     = 4,
    localparam int SEL_W     = $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mode,
    input  logic [SEL_W-1:0]             sel,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]            in_valid,
    output logic [NUM_CH-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [SEL_W-1:0]             out_ch
`ifdef STREAM_MUX_BEAT_CNT_EN
    ,
    output logic [15:0]                  beat_cnt
`endif
);

    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic [SEL_W-1:0]      out_ch_q, out_ch_d;
    logic [SEL_W-1:0]      rr_last_q, rr_last_d;

    logic                  load_en;
    logic [SEL_W-1:0]      grant;
    logic                  grant_valid;
    logic                  take;
    logic [DATA_WIDTH-1:0] word;
    int                    idx;

    // A slot is free when the register is empty or drains this cycle
    assign load_en = !out_valid_q || out_ready;

    // Grant: manual select, or first requester after the last RR winner
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = 0;
        if (mode) begin
            for (int k = 1; k <= NUM_CH; k++) begin
                idx = (int'(rr_last_q) + k) % NUM_CH;
                if (!grant_valid && in_valid[idx]) begin
                    grant       = SEL_W'(idx);
                    grant_valid = 1'b1;
                end
            end
        end else if (int'(sel) < NUM_CH) begin
            grant       = sel;
            grant_valid = 1'b1;
        end
    end

    // One-hot ready for the granted channel, suppressed in reset
    always_comb begin
        in_ready = '0;
        if (load_en && grant_valid && !rst) begin
            in_ready[grant] = 1'b1;
        end
    end

    assign take = |(in_valid & in_ready);
    assign word = in_data[grant*DATA_WIDTH +: DATA_WIDTH];

    // Next state: load on transfer, clear on drain without refill
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rr_last_d   = rr_last_q;
        if (take) begin
            out_valid_d = 1'b1;
            out_data_d  = word;
            out_ch_d    = grant;
            if (mode) begin
                rr_last_d = grant;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_last_q   <= SEL_W'(NUM_CH - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_last_q   <= rr_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

`ifdef STREAM_MUX_BEAT_CNT_EN
    logic [15:0] beat_cnt_q;

    // Count output transfers, wrapping at 16 bits
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q <= '0;
        end else if (out_valid_q && out_ready) begin
            beat_cnt_q <= beat_cnt_q + 16'd1;
        end
    end

    assign beat_cnt = beat_cnt_q;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr with a scoreboard of expected output words.
// Beat counter checks run only when STREAM_MUX_BEAT_CNT_EN is defined.
module tb_stream_mux_rr;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [15:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [3:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_ch;
`ifdef STREAM_MUX_BEAT_CNT_EN
    logic [15:0] beat_cnt;
`endif

    typedef struct packed {
        logic [1:0] ch;
        logic [3:0] d;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    stream_mux_rr #(.DATA_WIDTH(4), .NUM_CH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch)
`ifdef STREAM_MUX_BEAT_CNT_EN
        ,
        .beat_cnt  (beat_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check ready and output at the falling edge, then cross the rising edge
    task automatic step(input logic [3:0] exp_rdy, input string tag);
        exp_t e;
        @(negedge clk);
        chk({tag, "_rdy"}, {12'd0, in_ready}, {12'd0, exp_rdy});
        chk({tag, "_ov"}, {15'd0, out_valid}, {15'd0, sb.size() > 0});
        if (sb.size() > 0) begin
            e = sb[0];
            chk({tag, "_od"}, {12'd0, out_data}, {12'd0, e.d});
            chk({tag, "_och"}, {14'd0, out_ch}, {14'd0, e.ch});
            if (out_ready) e = sb.pop_front();
        end
        for (int i = 0; i < 4; i++) begin
            if (exp_rdy[i] && in_valid[i]) begin
                e.ch = 2'(i);
                e.d  = in_data[i*4 +: 4];
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        mode      = 1'b0;
        sel       = 2'd0;
        in_data   = {4'hD, 4'hA, 4'h7, 4'h3};
        in_valid  = 4'b1111;
        out_ready = 1'b1;

        // Reset held two cycles
        @(posedge clk);
        @(negedge clk);
        chk("rst_rdy", {12'd0, in_ready}, 16'd0);
        chk("rst_ov", {15'd0, out_valid}, 16'd0);
        chk("rst_od", {12'd0, out_data}, 16'd0);
        chk("rst_och", {14'd0, out_ch}, 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Manual select of ch2, then ready without valid, then drain
        sel = 2'd2;
        step(4'b0100, "man");
        in_valid = 4'b0000;
        step(4'b0100, "man_nov");
        step(4'b0100, "man_drn");

        // Round-robin over all channels, one word per cycle
        mode     = 1'b1;
        in_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            step(4'(1 << (i % 4)), "rr");
        end

        // Sparse requesters, idle cycles keep the pointer
        in_valid = 4'b0010;
        step(4'b0010, "sp_c1");
        in_valid = 4'b1010;
        step(4'b1000, "sp_c3");
        step(4'b0010, "sp_c1b");
        in_valid = 4'b0000;
        step(4'b0000, "sp_idle");
        step(4'b0000, "sp_idle2");
        in_valid = 4'b1010;
        step(4'b1000, "sp_c3b");
        in_valid = 4'b0000;
        step(4'b0000, "sp_drn");

        // Manual transfer must not move the RR pointer
        mode     = 1'b0;
        sel      = 2'd1;
        in_valid = 4'b1111;
        step(4'b0010, "mx_man");
        mode = 1'b1;
        step(4'b0001, "mx_rr");
        in_valid = 4'b0000;
        step(4'b0000, "mx_drn");

        // Backpressure holds word 5 for three cycles
        mode          = 1'b0;
        sel           = 2'd0;
        in_data[3:0]  = 4'h5;
        in_valid      = 4'b0001;
        step(4'b0001, "bp_ld");
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        sel       = 2'd1;
        for (int i = 0; i < 3; i++) begin
            step(4'b0000, "bp_hold");
        end
        out_ready = 1'b1;
        step(4'b0010, "bp_rel");
        in_valid = 4'b0000;
        step(4'b0010, "bp_next");

        // Fresh reset, five transfers, then reset with a word held
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        mode     = 1'b1;
        in_valid = 4'b1111;
        step(4'b0001, "cnt0");
        step(4'b0010, "cnt1");
        step(4'b0100, "cnt2");
        step(4'b1000, "cnt3");
        step(4'b0001, "cnt4");
        in_valid = 4'b0000;
        step(4'b0000, "cnt_drn");
        in_valid = 4'b1111;
        step(4'b0010, "cnt_ld");
`ifdef STREAM_MUX_BEAT_CNT_EN
        chk("cnt_pre", beat_cnt, 16'd5);
`endif
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_rdy", {12'd0, in_ready}, 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        chk("mrst_ov", {15'd0, out_valid}, 16'd0);
        chk("mrst_od", {12'd0, out_data}, 16'd0);
        chk("mrst_och", {14'd0, out_ch}, 16'd0);
`ifdef STREAM_MUX_BEAT_CNT_EN
        chk("cnt_post", beat_cnt, 16'd0);
`endif
        step(4'b0001, "mrst_rr");
        in_valid = 4'b0000;
        step(4'b0000, "end_drn");
        step(4'b0000, "end_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
